// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared types, defaults and index helper for the round-robin mux arbiter
package mux_arb_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } arb_state_t;

  localparam int DEF_N = 4;
  localparam int DEF_W = 4;

  // (base + off) mod n, valid when both operands are already below n
  function automatic int wrap_add(input int base, input int off, input int n);
    int s;
    s = base + off;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// rtl/mux_rr_arbiter_rr_pick.sv - combinational round-robin winner select from a rotating pointer
module rr_pick
  import mux_arb_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] winner,
  output logic             any
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic           found;

  // Rotating {req,req} right by ptr puts requester ptr at bit 0 of the scan window.
  always_comb begin
    dbl    = {req, req} >> ptr;
    rot    = dbl[N-1:0];
    winner = '0;
    found  = 1'b0;
    any    = |req;
    for (int i = 0; i < N; i++) begin
      if (!found && rot[i]) begin
        found  = 1'b1;
        winner = SEL_W'(wrap_add(int'(ptr), i, N));
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin owner of a shared W-bit mux with a 1-entry valid/ready output buffer
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = DEF_W,
  localparam int SEL_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     lock,
  input  logic [N*W-1:0]   in_data,
  output logic [N-1:0]     ack,
  output logic [SEL_W-1:0] mux_sel,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic [SEL_W-1:0] out_src,
  input  logic             out_ready
);

  arb_state_t       state_q, state_d;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] winner;
  logic             any;
  logic             load;
  logic [W-1:0]     words [N];

  for (genvar g = 0; g < N; g++) begin : g_words
    assign words[g] = in_data[g*W +: W];
  end

  rr_pick #(.N(N), .SEL_W(SEL_W)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (winner),
    .any    (any)
  );

  // Gated by rst_n so no ack leaks out while reset is held.
  assign load      = rst_n && any && (state_q == EMPTY || out_ready);
  assign out_valid = (state_q == FULL);

  always_comb begin
    ack     = '0;
    state_d = state_q;
    if (load) begin
      ack[winner] = 1'b1;
      state_d     = FULL;
    end else if (state_q == FULL && out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // A locked winner keeps the pointer so it stays first in line for the next load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_src  <= '0;
      mux_sel  <= '0;
      ptr      <= '0;
    end else if (load) begin
      out_data <= words[winner];
      out_src  <= winner;
      mux_sel  <= winner;
      ptr      <= lock[winner] ? winner : SEL_W'(wrap_add(int'(winner), 1, N));
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - directed self-checking bench for mux_rr_arbiter
module tb_mux_rr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [3:0]  lock;
  logic [15:0] in_data;
  logic [3:0]  ack;
  logic [1:0]  mux_sel;
  logic        out_valid;
  logic [3:0]  out_data;
  logic [1:0]  out_src;
  logic        out_ready;

  int errors;
  int checks;

  mux_rr_arbiter #(.N(4), .W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .lock      (lock),
    .in_data   (in_data),
    .ack       (ack),
    .mux_sel   (mux_sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp_ack [5];
    logic [3:0] exp_dat [5];
    logic [1:0] exp_src [5];
    errors = 0;
    checks = 0;

    rst_n     = 1'b0;
    req       = 4'b1111;
    lock      = 4'b0000;
    in_data   = {4'hD, 4'hC, 4'hB, 4'hA};
    out_ready = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_ack", 32'(ack), 32'd0);
      check("rst_sel", 32'(mux_sel), 32'd0);
      tick();
    end

    rst_n     = 1'b1;
    out_ready = 1'b1;
    exp_ack = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_dat = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hA};
    exp_src = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    for (int k = 0; k < 5; k++) begin
      #1;
      check("rr_ack", 32'(ack), 32'(exp_ack[k]));
      tick();
      check("rr_valid", 32'(out_valid), 32'd1);
      check("rr_data", 32'(out_data), 32'(exp_dat[k]));
      check("rr_src", 32'(out_src), 32'(exp_src[k]));
      check("rr_sel", 32'(mux_sel), 32'(exp_src[k]));
    end

    // drain: out_valid falls, last word retained (ptr now 1)
    req = 4'b0000;
    #1;
    check("drain_ack", 32'(ack), 32'd0);
    tick();
    check("drain_valid", 32'(out_valid), 32'd0);
    check("drain_data", 32'(out_data), 32'hA);

    req       = 4'b0100;
    out_ready = 1'b0;
    #1;
    check("bp_ack0", 32'(ack), 32'b0100);
    tick();
    for (int k = 0; k < 5; k++) begin
      check("bp_ack_hold", 32'(ack), 32'd0);
      check("bp_data", 32'(out_data), 32'hC);
      check("bp_valid", 32'(out_valid), 32'd1);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp_reload_ack", 32'(ack), 32'b0100);
    in_data[11:8] = 4'h7;
    tick();
    in_data[11:8] = 4'hC;
    check("bp_reload_data", 32'(out_data), 32'h7);
    check("bp_reload_valid", 32'(out_valid), 32'd1);

    // ptr = 3: wrap from 3 to 0
    req = 4'b1001;
    #1;
    check("wrap_ack3", 32'(ack), 32'b1000);
    tick();
    check("wrap_src3", 32'(out_src), 32'd3);
    check("wrap_data3", 32'(out_data), 32'hD);
    #1;
    check("wrap_ack0", 32'(ack), 32'b0001);
    tick();
    check("wrap_src0", 32'(out_src), 32'd0);
    req = 4'b0000;
    tick();
    check("sparse_valid", 32'(out_valid), 32'd0);
    check("sparse_data", 32'(out_data), 32'hA);
    check("sparse_src", 32'(out_src), 32'd0);

    // ptr = 1: first grant goes to 1, then locked requester 0 repeats
    req  = 4'b0011;
    lock = 4'b0001;
    #1;
    check("lock_first", 32'(ack), 32'b0010);
    tick();
    for (int k = 0; k < 3; k++) begin
      #1;
      check("lock_hold", 32'(ack), 32'b0001);
      tick();
      check("lock_src", 32'(out_src), 32'd0);
    end
    lock = 4'b0000;
    exp_ack[0] = 4'b0001;
    exp_ack[1] = 4'b0010;
    exp_ack[2] = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("unlock_ack", 32'(ack), 32'(exp_ack[k]));
      tick();
    end

    // ptr = 1 here; park a word with backpressure, then reset mid-cycle
    req       = 4'b0100;
    out_ready = 1'b0;
    tick();
    check("mid_full", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_ack", 32'(ack), 32'd0);
    check("mid_rst_sel", 32'(mux_sel), 32'd0);
    tick();
    rst_n = 1'b1;
    req   = 4'b1010;
    #1;
    check("post_rst_ack", 32'(ack), 32'b0010);
    tick();
    check("post_rst_data", 32'(out_data), 32'hB);
    check("post_rst_src", 32'(out_src), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
